// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Desc     : Fetch PC generator feeding a DEPTH-entry prefetch FIFO; optional
//            direct-mapped BTB enabled by defining FQ_BTB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 4,
    parameter int BTB_ENTRIES = 16
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic [ADDR_W-1:0]          startPC,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [DATA_W-1:0]          imem_data,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    input  logic                       deq_ready,
    output logic                       deq_valid,
    output logic [DATA_W-1:0]          deq_instr,
    output logic [ADDR_W-1:0]          deq_pcplus4,
    output logic                       deq_pred_taken,
    output logic [$clog2(DEPTH):0]     count,
    input  logic                       btb_wr,
    input  logic [ADDR_W-1:0]          btb_wr_pc,
    input  logic [ADDR_W-1:0]          btb_wr_target,
    input  logic                       btb_wr_taken
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full    = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [ADDR_W-1:0]  c_four    = ADDR_W'(4);

    logic [ADDR_W-1:0]  r_pc;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [DATA_W-1:0]  r_instr [DEPTH];
    logic [ADDR_W-1:0]  r_pcp4  [DEPTH];

    logic               w_deq;
    logic               w_enq;
    logic               w_hit;
    logic [ADDR_W-1:0]  w_pcp4;
    logic [ADDR_W-1:0]  w_next_pc;

    assign imem_addr   = r_pc;
    assign deq_valid   = (r_count != '0);
    assign count       = r_count;
    assign deq_instr   = r_instr[r_rd_ptr];
    assign deq_pcplus4 = r_pcp4[r_rd_ptr];

    assign w_deq  = deq_valid && deq_ready;
    assign w_enq  = !redirect && ((r_count != c_full) || w_deq);
    assign w_pcp4 = r_pc + c_four;

`ifdef FQ_BTB_EN
    localparam int c_idx_w = $clog2(BTB_ENTRIES);
    localparam int c_tag_w = ADDR_W - c_idx_w - 2;

    logic [BTB_ENTRIES-1:0] r_btb_valid;
    logic [c_tag_w-1:0]     r_btb_tag    [BTB_ENTRIES];
    logic [ADDR_W-1:0]      r_btb_target [BTB_ENTRIES];
    logic                   r_pred       [DEPTH];

    logic [c_idx_w-1:0]     w_lk_idx;
    logic [c_idx_w-1:0]     w_wr_idx;
    logic [c_tag_w-1:0]     w_wr_tag;
    logic                   w_unused_lsb;

    assign w_lk_idx     = r_pc[c_idx_w+1:2];
    assign w_wr_idx     = btb_wr_pc[c_idx_w+1:2];
    assign w_wr_tag     = btb_wr_pc[ADDR_W-1:c_idx_w+2];
    assign w_unused_lsb = ^btb_wr_pc[1:0];
    assign w_hit        = r_btb_valid[w_lk_idx] &&
                          (r_btb_tag[w_lk_idx] == r_pc[ADDR_W-1:c_idx_w+2]);
    assign w_next_pc    = w_hit ? r_btb_target[w_lk_idx] : w_pcp4;
    // Gate with valid so stale storage never shows a prediction.
    assign deq_pred_taken = deq_valid && r_pred[r_rd_ptr];

    // Updates land regardless of redirect; lookup this cycle sees old contents.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_btb_valid <= '0;
        end else if (btb_wr) begin
            if (btb_wr_taken) begin
                r_btb_valid[w_wr_idx]  <= 1'b1;
                r_btb_tag[w_wr_idx]    <= w_wr_tag;
                r_btb_target[w_wr_idx] <= btb_wr_target;
            end else if (r_btb_tag[w_wr_idx] == w_wr_tag) begin
                r_btb_valid[w_wr_idx]  <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_enq) begin
            r_pred[r_wr_ptr] <= w_hit;
        end
    end
`else
    logic w_unused_btb;

    assign w_unused_btb   = ^{btb_wr, btb_wr_pc, btb_wr_target, btb_wr_taken};
    assign w_hit          = 1'b0;
    assign w_next_pc      = w_pcp4;
    assign deq_pred_taken = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (w_enq) begin
            r_instr[r_wr_ptr] <= imem_data;
            r_pcp4[r_wr_ptr]  <= w_pcp4;
        end
    end

    // Reset outranks redirect, which outranks enq/deq.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_pc     <= startPC;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect) begin
            r_pc     <= redirect_pc;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_pc     <= w_next_pc;
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Desc     : Directed self-checking bench for fetch_queue (BTB checks under
//            FQ_BTB_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        Reset;
    logic [31:0] startPC;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        deq_ready;
    logic        deq_valid;
    logic [31:0] deq_instr;
    logic [31:0] deq_pcplus4;
    logic        deq_pred_taken;
    logic [2:0]  count;
    logic        btb_wr;
    logic [31:0] btb_wr_pc;
    logic [31:0] btb_wr_target;
    logic        btb_wr_taken;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign imem_data = rom(imem_addr);

    fetch_queue #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(4), .BTB_ENTRIES(16)
    ) dut (
        .CLK(clk), .Reset(Reset), .startPC(startPC),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .deq_ready(deq_ready), .deq_valid(deq_valid),
        .deq_instr(deq_instr), .deq_pcplus4(deq_pcplus4),
        .deq_pred_taken(deq_pred_taken), .count(count),
        .btb_wr(btb_wr), .btb_wr_pc(btb_wr_pc),
        .btb_wr_target(btb_wr_target), .btb_wr_taken(btb_wr_taken)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Head entry must match the instruction fetched from pcp4-4.
    task automatic check_head(input string tag, input logic [31:0] pcp4, input logic pred);
        check({tag, "_valid"}, {31'd0, deq_valid}, 32'd1);
        check({tag, "_pcp4"}, deq_pcplus4, pcp4);
        check({tag, "_instr"}, deq_instr, rom(pcp4 - 32'd4));
        check({tag, "_pred"}, {31'd0, deq_pred_taken}, {31'd0, pred});
    endtask

    initial begin
        logic [31:0] exp_pc;

        Reset = 1'b1; startPC = 32'h0040_0000; redirect = 1'b0; redirect_pc = '0;
        deq_ready = 1'b0; btb_wr = 1'b0; btb_wr_pc = '0; btb_wr_target = '0;
        btb_wr_taken = 1'b0;
        step();
        check("rst_valid", {31'd0, deq_valid}, 32'd0);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_pred", {31'd0, deq_pred_taken}, 32'd0);
        check("rst_addr", imem_addr, 32'h0040_0000);

        // Streaming: one in, one out every cycle after the first.
        Reset = 1'b0; deq_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_head("stream", 32'h0040_0004 + 32'(4 * i), 1'b0);
            check("stream_count", {29'd0, count}, 32'd1);
        end

        // Fill with decode stalled.
        Reset = 1'b1; step();
        Reset = 1'b0; deq_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            check("fill_count", {29'd0, count}, (i < 4) ? 32'(i) : 32'd4);
        end
        check("fill_addr", imem_addr, 32'h0040_0010);
        check_head("fill_head", 32'h0040_0004, 1'b0);

        // Full with simultaneous deq/enq across pointer wrap.
        deq_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_head("wrap", 32'h0040_0008 + 32'(4 * i), 1'b0);
            check("wrap_count", {29'd0, count}, 32'd4);
        end

        // Redirect with three entries queued and decode ready.
        Reset = 1'b1; step();
        Reset = 1'b0; deq_ready = 1'b0;
        repeat (3) step();
        check("pre_redir_count", {29'd0, count}, 32'd3);
        redirect = 1'b1; redirect_pc = 32'h0040_0100; deq_ready = 1'b1;
        step();
        check("redir_count", {29'd0, count}, 32'd0);
        check("redir_valid", {31'd0, deq_valid}, 32'd0);
        check("redir_addr", imem_addr, 32'h0040_0100);
        redirect = 1'b0; deq_ready = 1'b0;
        step();
        check_head("redir_first", 32'h0040_0104, 1'b0);
        check("redir_first_count", {29'd0, count}, 32'd1);

        // Reset outranks redirect.
        Reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0800;
        step();
        check("prio_addr", imem_addr, 32'h0040_0000);
        check("prio_count", {29'd0, count}, 32'd0);
        redirect = 1'b0;

        // Address wrap at the top of the address space.
        startPC = 32'hFFFF_FFF8;
        step();
        check("pcwrap_addr", imem_addr, 32'hFFFF_FFF8);
        Reset = 1'b0; deq_ready = 1'b1;
        exp_pc = 32'hFFFF_FFFC;
        for (int i = 0; i < 3; i++) begin
            step();
            check_head("pcwrap", exp_pc, 1'b0);
            exp_pc = exp_pc + 32'd4;
        end

`ifdef FQ_BTB_EN
        // Install entry during a redirect, then refetch through it.
        Reset = 1'b1; startPC = 32'h0040_0000; step();
        Reset = 1'b0; deq_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h0040_0000;
        btb_wr = 1'b1; btb_wr_pc = 32'h0040_0008; btb_wr_target = 32'h0040_0040;
        btb_wr_taken = 1'b1;
        step();
        redirect = 1'b0; btb_wr = 1'b0; deq_ready = 1'b1;
        step(); check_head("btb_a", 32'h0040_0004, 1'b0);
        step(); check_head("btb_b", 32'h0040_0008, 1'b0);
        step(); check_head("btb_hit", 32'h0040_000C, 1'b1);
        step(); check_head("btb_tgt", 32'h0040_0044, 1'b0);

        // Invalidate and confirm sequential fetch.
        redirect = 1'b1; redirect_pc = 32'h0040_0000;
        btb_wr = 1'b1; btb_wr_taken = 1'b0;
        step();
        redirect = 1'b0; btb_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_head("btb_inv", 32'h0040_0004 + 32'(4 * i), 1'b0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
